// File: rtl/button_events_pkg.sv
// button_events_pkg: shared FSM state encoding for the button event block.
// Front-panel consumers and benches import this so every place decodes state alike.
package button_events_pkg;

   // 2-bit state encoding; LOCKOUT is the reset state.
   typedef enum logic [1:0] {
      ST_LOCKOUT = 2'd0,
      ST_IDLE    = 2'd1,
      ST_PRESS   = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   localparam int DEF_CNT_W         = 16;
   localparam int DEF_LONG_CYCLES   = 50000;
   localparam int DEF_REPEAT_CYCLES = 10000;

endpackage

// File: rtl/button_events.sv
// button_events: turns a debounced button level into registered 1-cycle events.
// Ports: CLK, RESET_n (async, active low), btn_state (1 = pressed) in;
//        held (level), press, release_evt, click, long_press, repeat_evt (pulses) out.
module button_events
   import button_events_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic CLK,
   input  logic RESET_n,
   input  logic btn_state,
   output logic held,
   output logic press,
   output logic release_evt,
   output logic click,
   output logic long_press,
   output logic repeat_evt
);

   // Terminal counts as CNT_W-bit constants so compares never widen.
   localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_TERM  =
      (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);
   localparam logic             REP_EN    = (REPEAT_CYCLES != 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // Saturating increment: with repeat disabled the hold count parks at all-ones.
   assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state       <= ST_LOCKOUT;
         cnt         <= '0;
         held        <= 1'b0;
         press       <= 1'b0;
         release_evt <= 1'b0;
         click       <= 1'b0;
         long_press  <= 1'b0;
         repeat_evt  <= 1'b0;
      end else begin
         press       <= 1'b0;
         release_evt <= 1'b0;
         click       <= 1'b0;
         long_press  <= 1'b0;
         repeat_evt  <= 1'b0;
         case (state)
            // A button held through reset must be let go before it can press.
            ST_LOCKOUT: begin
               held <= 1'b0;
               cnt  <= '0;
               if (!btn_state) state <= ST_IDLE;
            end
            ST_IDLE: begin
               held <= 1'b0;
               cnt  <= '0;
               if (btn_state) begin
                  state <= ST_PRESS;
                  press <= 1'b1;
                  held  <= 1'b1;
               end
            end
            // Release is checked first so it wins over a terminal count.
            ST_PRESS: begin
               if (!btn_state) begin
                  state       <= ST_IDLE;
                  release_evt <= 1'b1;
                  click       <= 1'b1;
                  held        <= 1'b0;
                  cnt         <= '0;
               end else if (cnt == LONG_TERM) begin
                  state      <= ST_HOLD;
                  long_press <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ST_HOLD: begin
               if (!btn_state) begin
                  state       <= ST_IDLE;
                  release_evt <= 1'b1;
                  held        <= 1'b0;
                  cnt         <= '0;
               end else if (REP_EN && (cnt == REP_TERM)) begin
                  repeat_evt <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= ST_LOCKOUT;
               held  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed bench for button_events (LONG=8, REPEAT=4/0, CNT_W=4).
// Event vector order: {held, press, release_evt, click, long_press, repeat_evt}.
module tb_button_events;
   import button_events_pkg::*;

   logic CLK;
   logic RESET_n;
   logic btn;
   logic btn_b;

   logic a_held, a_press, a_rel, a_click, a_long, a_rep;
   logic b_held, b_press, b_rel, b_click, b_long, b_rep;
   logic [5:0] ev_a;
   logic [5:0] ev_b;

   int checks;
   int errors;

   assign ev_a = {a_held, a_press, a_rel, a_click, a_long, a_rep};
   assign ev_b = {b_held, b_press, b_rel, b_click, b_long, b_rep};

   button_events #(.CNT_W(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) u_a (
      .CLK(CLK), .RESET_n(RESET_n), .btn_state(btn),
      .held(a_held), .press(a_press), .release_evt(a_rel),
      .click(a_click), .long_press(a_long), .repeat_evt(a_rep)
   );

   button_events #(.CNT_W(4), .LONG_CYCLES(8), .REPEAT_CYCLES(0)) u_b (
      .CLK(CLK), .RESET_n(RESET_n), .btn_state(btn_b),
      .held(b_held), .press(b_press), .release_evt(b_rel),
      .click(b_click), .long_press(b_long), .repeat_evt(b_rep)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one edge; outputs are then stable and inputs may change.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET_n = 1'b0;
      btn     = 1'b1;
      btn_b   = 1'b0;
      #2;
      checks++;
      if (ev_a !== 6'b000000) begin
         $display("FAIL reset_async got %b exp %b", ev_a, 6'b000000);
         errors++;
      end
      tick();
      tick();
      checks++;
      if (ev_a !== 6'b000000 || u_a.state !== ST_LOCKOUT) begin
         $display("FAIL reset_state got %b/%0d exp 000000/0", ev_a, u_a.state);
         errors++;
      end
   endtask

   task automatic test_lockout();
      RESET_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ev_a !== 6'b000000) begin
            $display("FAIL lockout_held c%0d got %b exp 000000", i, ev_a);
            errors++;
         end
      end
      btn = 1'b0;
      tick();
      checks++;
      if (ev_a !== 6'b000000) begin
         $display("FAIL lockout_drop got %b exp 000000", ev_a);
         errors++;
      end
      btn = 1'b1;
      tick();
      checks++;
      if (ev_a !== 6'b110000) begin
         $display("FAIL lockout_repress got %b exp 110000", ev_a);
         errors++;
      end
      tick();
      checks++;
      if (ev_a !== 6'b100000) begin
         $display("FAIL lockout_held_lvl got %b exp 100000", ev_a);
         errors++;
      end
      btn = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_click();
      logic [5:0] exp;
      btn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         exp = (k == 0) ? 6'b110000 : 6'b100000;
         checks++;
         if (ev_a !== exp) begin
            $display("FAIL click_hold c%0d got %b exp %b", k, ev_a, exp);
            errors++;
         end
      end
      btn = 1'b0;
      tick();
      checks++;
      if (ev_a !== 6'b001100) begin
         $display("FAIL click_release got %b exp 001100", ev_a);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      btn = 1'b1;
      tick();
      checks++;
      if (ev_a !== 6'b110000) begin
         $display("FAIL b2b_press got %b exp 110000", ev_a);
         errors++;
      end
      btn = 1'b0;
      tick();
      checks++;
      if (ev_a !== 6'b001100) begin
         $display("FAIL b2b_release got %b exp 001100", ev_a);
         errors++;
      end
      tick();
      checks++;
      if (ev_a !== 6'b000000) begin
         $display("FAIL b2b_idle got %b exp 000000", ev_a);
         errors++;
      end
   endtask

   task automatic test_long_repeat();
      logic [5:0] exp;
      int n_long;
      int n_rep;
      n_long = 0;
      n_rep  = 0;
      btn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k == 0)                exp = 6'b110000;
         else if (k == 8)           exp = 6'b100010;
         else if (k == 12 || k == 16) exp = 6'b100001;
         else                       exp = 6'b100000;
         n_long += int'(a_long);
         n_rep  += int'(a_rep);
         checks++;
         if (ev_a !== exp) begin
            $display("FAIL long_hold c%0d got %b exp %b", k, ev_a, exp);
            errors++;
         end
      end
      btn = 1'b0;
      tick();
      checks++;
      if (ev_a !== 6'b001000) begin
         $display("FAIL long_release got %b exp 001000", ev_a);
         errors++;
      end
      checks++;
      if (n_long != 1 || n_rep != 2) begin
         $display("FAIL long_counts got %0d/%0d exp 1/2", n_long, n_rep);
         errors++;
      end
      tick();
   endtask

   task automatic test_release_at_terminal();
      logic [5:0] exp;
      btn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         exp = (k == 0) ? 6'b110000 : 6'b100000;
         checks++;
         if (ev_a !== exp) begin
            $display("FAIL term_hold c%0d got %b exp %b", k, ev_a, exp);
            errors++;
         end
      end
      btn = 1'b0;
      tick();
      checks++;
      if (ev_a !== 6'b001100) begin
         $display("FAIL term_release got %b exp 001100", ev_a);
         errors++;
      end
      tick();
      checks++;
      if (ev_a !== 6'b000000) begin
         $display("FAIL term_after got %b exp 000000", ev_a);
         errors++;
      end
   endtask

   task automatic test_no_repeat();
      logic [5:0] exp;
      btn_b = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (k == 0)      exp = 6'b110000;
         else if (k == 8) exp = 6'b100010;
         else             exp = 6'b100000;
         checks++;
         if (ev_b !== exp) begin
            $display("FAIL norep_hold c%0d got %b exp %b", k, ev_b, exp);
            errors++;
         end
      end
      checks++;
      if (u_b.cnt !== 4'hF) begin
         $display("FAIL norep_sat got %h exp f", u_b.cnt);
         errors++;
      end
      btn_b = 1'b0;
      tick();
      checks++;
      if (ev_b !== 6'b001000) begin
         $display("FAIL norep_release got %b exp 001000", ev_b);
         errors++;
      end
      tick();
   endtask

   task automatic test_reset_in_hold();
      btn = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (ev_a !== 6'b100000 || u_a.state !== ST_HOLD) begin
         $display("FAIL rst_pre got %b/%0d exp 100000/3", ev_a, u_a.state);
         errors++;
      end
      RESET_n = 1'b0;
      #1;
      checks++;
      if (ev_a !== 6'b000000 || u_a.state !== ST_LOCKOUT) begin
         $display("FAIL rst_hold got %b/%0d exp 000000/0", ev_a, u_a.state);
         errors++;
      end
      tick();
      RESET_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (ev_a !== 6'b000000) begin
            $display("FAIL rst_after c%0d got %b exp 000000", k, ev_a);
            errors++;
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lockout();
      test_click();
      test_back_to_back();
      test_long_repeat();
      test_release_at_terminal();
      test_no_repeat();
      test_reset_in_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
